// File: rtl/keypad_scan4x4.sv
// keypad_scan4x4 -- 4x4 matrix keypad scanner with debounce and key latch.
//
// Drives one row low at a time, watches the synchronized column lines and
// accepts a single key per press/release after DEBOUNCE_TICKS stable scan
// ticks. An accepted code is held in o_key until the consumer acknowledges
// it. A later accept overwrites o_key and flags o_overrun.
//
// Parameters:
//   SCAN_DIV_W      scan tick period is 2^SCAN_DIV_W CLK cycles
//   DEBOUNCE_TICKS  stable ticks needed to accept a press or a release
//
// Ports:
//   CLK          system clock, rising edge
//   reset        asynchronous, active-high reset
//   i_col[3:0]   column lines, active-low, asynchronous to CLK
//   i_key_ack    one-cycle read strobe; clears o_key_valid and o_overrun
//   o_row[3:0]   row drive, active-low one-hot
//   o_key[3:0]   last accepted key code {row, col}
//   o_key_valid  an unread key is held in o_key
//   o_overrun    sticky, a key was accepted while o_key_valid was set
//   o_pressed    the accepted key is still held down
//   o_history    last 8 key codes, newest in [3:0]
//
// Build option: define KEYPAD_HISTORY_EN to enable the o_history shift
// register. Without it o_history reads as zero.
module keypad_scan4x4 #(
  parameter int SCAN_DIV_W     = 15,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [3:0]  i_col,
  input  logic        i_key_ack,
  output logic [3:0]  o_row,
  output logic [3:0]  o_key,
  output logic        o_key_valid,
  output logic        o_overrun,
  output logic        o_pressed,
  output logic [31:0] o_history
);

  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  logic [3:0]            col_meta_q;
  logic [3:0]            col_s_q;
  logic [SCAN_DIV_W-1:0] div_q;
  state_t                state_q;
  logic [1:0]            r_q;
  logic [3:0]            row_q;
  logic [3:0]            latch_q;
  logic [DB_W-1:0]       dbcnt_q;
  logic [3:0]            key_q;
  logic                  valid_q;
  logic                  ovr_q;
  logic                  pressed_q;

  logic                  tick_d;
  logic                  one_low_d;
  logic                  db_done_d;
  logic                  accept_d;
  logic [1:0]            c_d;
  logic [3:0]            code_d;

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  // Tick is a one-cycle enable, never a clock.
  assign tick_d    = &div_q;
  assign one_low_d = $onehot(~col_s_q);
  // dbcnt is about to be incremented to DEBOUNCE_TICKS on this tick.
  assign db_done_d = (dbcnt_q == DB_W'(DEBOUNCE_TICKS - 1));
  assign accept_d  = tick_d && (state_q == ST_DEBOUNCE) &&
                     (col_s_q == latch_q) && db_done_d;

  always_comb begin
    c_d = 2'd0;
    case (latch_q)
      4'b1110: c_d = 2'd0;
      4'b1101: c_d = 2'd1;
      4'b1011: c_d = 2'd2;
      4'b0111: c_d = 2'd3;
      default: c_d = 2'd0;
    endcase
  end

  assign code_d = {r_q, c_d};

  // Column synchronizer and free-running scan divider.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
      div_q      <= '0;
    end else begin
      col_meta_q <= i_col;
      col_s_q    <= col_meta_q;
      div_q      <= div_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SCAN;
      r_q       <= 2'd0;
      row_q     <= 4'b1110;
      latch_q   <= 4'hF;
      dbcnt_q   <= '0;
      key_q     <= 4'h0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      if (tick_d) begin
        case (state_q)
          ST_SCAN: begin
            if (one_low_d) begin
              latch_q <= col_s_q;
              dbcnt_q <= '0;
              state_q <= ST_DEBOUNCE;
            end else begin
              // No key, or several keys on this row: keep scanning.
              r_q   <= r_q + 2'd1;
              row_q <= row_drive(r_q + 2'd1);
            end
          end
          ST_DEBOUNCE: begin
            if (col_s_q == latch_q) begin
              dbcnt_q <= dbcnt_q + DB_W'(1);
              if (db_done_d) begin
                state_q   <= ST_HOLD;
                pressed_q <= 1'b1;
              end
            end else begin
              state_q <= ST_SCAN;
              r_q     <= r_q + 2'd1;
              row_q   <= row_drive(r_q + 2'd1);
            end
          end
          ST_HOLD: begin
            if (col_s_q == 4'hF) begin
              dbcnt_q   <= '0;
              state_q   <= ST_RELEASE;
              pressed_q <= 1'b0;
            end
          end
          ST_RELEASE: begin
            if (col_s_q == 4'hF) begin
              dbcnt_q <= dbcnt_q + DB_W'(1);
              if (db_done_d) begin
                state_q <= ST_SCAN;
                r_q     <= r_q + 2'd1;
                row_q   <= row_drive(r_q + 2'd1);
              end
            end else begin
              // Bounce during release: the same press is still going on.
              state_q   <= ST_HOLD;
              pressed_q <= 1'b1;
            end
          end
          default: state_q <= ST_SCAN;
        endcase
      end

      // Accept has priority over a same-cycle ack; an ack in that cycle
      // means the previous key was read, so it is not an overrun.
      if (accept_d) begin
        key_q   <= code_d;
        valid_q <= 1'b1;
        ovr_q   <= valid_q & ~i_key_ack;
      end else if (i_key_ack) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

`ifdef KEYPAD_HISTORY_EN
  logic [31:0] hist_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      hist_q <= 32'h0;
    end else if (accept_d) begin
      hist_q <= {hist_q[27:0], code_d};
    end
  end

  assign o_history = hist_q;
`else
  assign o_history = 32'h0;
`endif

  assign o_row       = row_q;
  assign o_key       = key_q;
  assign o_key_valid = valid_q;
  assign o_overrun   = ovr_q;
  assign o_pressed   = pressed_q;

endmodule
